// File: rtl/paso8bto1b_pkg.sv
// Constants and state encoding shared by the paso8bto1b serializer and its matching deserializer.
package paso8bto1b_pkg;

    localparam logic [7:0] COMMA_DEFAULT  = 8'hBC;
    localparam int         N_SYNC_DEFAULT = 4;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/paso8bto1b_if.sv
// Byte-side and serial-side signals of the paso8bto1b serializer.
interface paso8bto1b_if;

    logic [7:0] data_in;
    logic       valid_in;
    logic       data_out;
    logic       valid_out;
    logic       byte_start;
    logic       ready;

    modport master (
        output data_in, valid_in,
        input  data_out, valid_out, byte_start, ready
    );

    modport slave (
        input  data_in, valid_in,
        output data_out, valid_out, byte_start, ready
    );

endinterface

// File: rtl/bit_counter_mod8.sv
// Mod-8 bit counter: bit_cnt counts 7..0 and load flags the edge on which a new byte is taken.
module bit_counter_mod8 (
    input  logic clk,
    input  logic reset,
    output logic load
);

    logic [2:0] bit_cnt;
    logic       started;

    // The first edge after reset loads without decrementing, so every byte, including the first, lasts 8 cycles.
    assign load = !started || (bit_cnt == 3'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= 3'd7;
            started <= 1'b0;
        end else begin
            started <= 1'b1;
            bit_cnt <= load ? 3'd7 : bit_cnt - 3'd1;
        end
    end

endmodule

// File: rtl/paso8bto1b.sv
// Byte-to-serial converter with post-reset comma training burst.
// Define PASO8BTO1B_LSB_FIRST_EN to transmit bytes LSB first instead of MSB first.
module paso8bto1b
    import paso8bto1b_pkg::*;
#(
    parameter int         N_SYNC = N_SYNC_DEFAULT,
    parameter logic [7:0] COMMA  = COMMA_DEFAULT
) (
    input  logic            clk_32f,
    input  logic            reset,
    paso8bto1b_if.slave     bus
);

    localparam logic [3:0] SYNC_LAST = 4'(N_SYNC - 1);

    logic       load;
    state_t     state, state_next;
    logic [3:0] sync_cnt, sync_cnt_next;
    logic [7:0] byte_sel;
    logic       byte_is_data;
    logic [7:0] shreg, shreg_next;
    logic       bit_next;
    logic       data_out, valid_out, byte_start;

    bit_counter_mod8 u_bit_counter (
        .clk   (clk_32f),
        .reset (reset),
        .load  (load)
    );

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state    <= SYNC;
            sync_cnt <= 4'd0;
        end else begin
            state    <= state_next;
            sync_cnt <= sync_cnt_next;
        end
    end

    // Upstream bytes are dropped while training; the last training byte is still a comma.
    always_comb begin
        state_next    = state;
        sync_cnt_next = sync_cnt;
        byte_sel      = COMMA;
        byte_is_data  = 1'b0;
        if (load) begin
            case (state)
                SYNC: begin
                    sync_cnt_next = sync_cnt + 4'd1;
                    if (sync_cnt == SYNC_LAST)
                        state_next = ACTIVE;
                end
                ACTIVE: begin
                    if (bus.valid_in) begin
                        byte_sel     = bus.data_in;
                        byte_is_data = 1'b1;
                    end
                end
                default: state_next = SYNC;
            endcase
        end
    end

`ifdef PASO8BTO1B_LSB_FIRST_EN
    assign shreg_next = load ? byte_sel : {1'b0, shreg[7:1]};
    assign bit_next   = shreg_next[0];
`else
    assign shreg_next = load ? byte_sel : {shreg[6:0], 1'b0};
    assign bit_next   = shreg_next[7];
`endif

    // Output stage: the bit leaving the register appears one cycle after its load/shift edge.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            shreg      <= 8'h00;
            data_out   <= 1'b0;
            valid_out  <= 1'b0;
            byte_start <= 1'b0;
        end else begin
            shreg      <= shreg_next;
            data_out   <= bit_next;
            byte_start <= load;
            if (load)
                valid_out <= byte_is_data;
        end
    end

    assign bus.data_out   = data_out;
    assign bus.valid_out  = valid_out;
    assign bus.byte_start = byte_start;
    assign bus.ready      = (state == ACTIVE);

endmodule
